// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Desc     : Round-robin, burst-limited arbiter sharing one FIFO write port
//            among NUM_REQ producers, with FIFO-full back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          busy
);

    localparam int                 c_idx_w     = $clog2(NUM_REQ);
    localparam logic [3:0]         c_last_beat = 4'(MAX_BURST - 1);
    localparam logic [c_idx_w-1:0] c_first_own = c_idx_w'(NUM_REQ - 1);
    localparam logic [0:0]         c_s_idle    = 1'b0;
    localparam logic [0:0]         c_s_grant   = 1'b1;

    logic [0:0]            r_state;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [c_idx_w-1:0]    r_last_owner;
    logic [3:0]            r_beat_cnt;

    logic [0:0]            w_state_nxt;
    logic [NUM_REQ-1:0]    w_gnt_nxt;
    logic [c_idx_w-1:0]    w_last_nxt;
    logic [3:0]            w_cnt_nxt;

    logic                  w_owner_req;
    logic [DATA_WIDTH-1:0] w_owner_data;
    logic                  w_beat;
    logic                  w_arb;
    logic                  w_found;
    logic [c_idx_w-1:0]    w_winner;
    logic [NUM_REQ-1:0]    w_win_onehot;

    // While a grant is held, last_owner is the owner's index.
    always_comb begin
        w_owner_req  = 1'b0;
        w_owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_last_owner == c_idx_w'(i)) begin
                w_owner_req  = req[i];
                w_owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_beat = (r_state == c_s_grant) && w_owner_req && !fifo_full;

    // Two ascending passes: indices above last_owner first, then wrap around
    // so that last_owner itself is considered last.
    always_comb begin
        w_found      = 1'b0;
        w_winner     = '0;
        w_win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i] && (c_idx_w'(i) > r_last_owner)) begin
                w_found         = 1'b1;
                w_winner        = c_idx_w'(i);
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i] && (c_idx_w'(i) <= r_last_owner)) begin
                w_found         = 1'b1;
                w_winner        = c_idx_w'(i);
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last_owner;
        w_cnt_nxt   = r_beat_cnt;
        w_arb       = 1'b0;
        case (r_state)
            c_s_idle: begin
                w_arb = |req;
            end
            c_s_grant: begin
                // A full stall holds everything unless the owner lets go.
                if (!w_owner_req || (w_beat && (r_beat_cnt == c_last_beat))) begin
                    w_arb = 1'b1;
                end else if (w_beat) begin
                    w_cnt_nxt = r_beat_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_s_idle;
                w_gnt_nxt   = '0;
            end
        endcase
        if (w_arb) begin
            if (w_found) begin
                w_state_nxt = c_s_grant;
                w_gnt_nxt   = w_win_onehot;
                w_last_nxt  = w_winner;
                w_cnt_nxt   = 4'd0;
            end else begin
                w_state_nxt = c_s_idle;
                w_gnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state      <= c_s_idle;
            r_gnt        <= '0;
            r_last_owner <= c_first_own;
            r_beat_cnt   <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_last_owner <= w_last_nxt;
            r_beat_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt          = r_gnt;
    assign busy         = |r_gnt;
    assign fifo_wr      = w_beat;
    assign fifo_data_in = w_beat ? w_owner_data : '0;

endmodule
`default_nettype wire
